// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter
// Drains two source FIFOs into one downstream FIFO. A port keeps its grant
// for up to BURST_LEN words; a tie goes to the port that was not served last.
// Read data comes back one cycle after the pop and is re-registered, so a
// word appears on data_out two cycles after its read strobe.
//
// Parameters: DATA_WIDTH (word width), BURST_LEN (1..15 words per grant)
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   empty0/1            source FIFO empty flags
//   fifo_out0/1         source read data (valid the cycle after readN)
//   almost_full_dst     downstream cannot take more words (needs 2 words slack)
//   read0/1             pop strobes to the sources
//   data_out, valid_out word and write strobe to the downstream FIFO
//   grant               one-hot current owner (01 FIFO0, 10 FIFO1, 00 idle)
//   cnt0/1              delivered-word counters, only with FIFO_RD_ARBITER_STATS_EN
//
// state | meaning
// IDLE  | no owner; one bubble cycle between bursts, picks the next owner
// GNT0  | FIFO0 owns the output, draining up to BURST_LEN words
// GNT1  | FIFO1 owns the output, draining up to BURST_LEN words
module fifo_rd_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty0,
  input  logic                  empty1,
  input  logic [DATA_WIDTH-1:0] fifo_out0,
  input  logic [DATA_WIDTH-1:0] fifo_out1,
  input  logic                  almost_full_dst,
  output logic                  read0,
  output logic                  read1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [1:0]            grant
`ifdef FIFO_RD_ARBITER_STATS_EN
  ,
  output logic [15:0]           cnt0,
  output logic [15:0]           cnt1
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);

  logic [1:0] state, state_nxt;
  logic [3:0] burst_cnt, burst_cnt_nxt;
  logic       last_grant, last_grant_nxt;  // 1 = FIFO1 was served last
  logic       rd_p1;                       // a read was issued last cycle
  logic       rd_p1_src;                   // ...and it came from FIFO1

  // Strobes and grant are forced low during reset so a mid-burst reset
  // cannot pop a word that the cleared pipeline would then lose track of.
  assign read0 = !reset && (state == GNT0) && !empty0 && !almost_full_dst;
  assign read1 = !reset && (state == GNT1) && !empty1 && !almost_full_dst;

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (state == GNT0)      grant = 2'b01;
      else if (state == GNT1) grant = 2'b10;
    end
  end

  always_comb begin
    state_nxt      = state;
    burst_cnt_nxt  = burst_cnt;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (!almost_full_dst && !(empty0 && empty1)) begin
          burst_cnt_nxt = 4'd0;
          if (!empty0 && (empty1 || last_grant)) begin
            state_nxt      = GNT0;
            last_grant_nxt = 1'b0;
          end else begin
            state_nxt      = GNT1;
            last_grant_nxt = 1'b1;
          end
        end
      end
      GNT0: begin
        if (empty0) begin
          state_nxt = IDLE;
        end else if (read0) begin
          if (burst_cnt == BURST_LAST) state_nxt = IDLE;
          else                         burst_cnt_nxt = burst_cnt + 4'd1;
        end
      end
      GNT1: begin
        if (empty1) begin
          state_nxt = IDLE;
        end else if (read1) begin
          if (burst_cnt == BURST_LAST) state_nxt = IDLE;
          else                         burst_cnt_nxt = burst_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      burst_cnt  <= 4'd0;
      last_grant <= 1'b1;
      rd_p1      <= 1'b0;
      rd_p1_src  <= 1'b0;
      valid_out  <= 1'b0;
      data_out   <= '0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      last_grant <= last_grant_nxt;
      rd_p1      <= read0 | read1;
      rd_p1_src  <= read1;
      valid_out  <= rd_p1;
      if (rd_p1) data_out <= rd_p1_src ? fifo_out1 : fifo_out0;
    end
  end

`ifdef FIFO_RD_ARBITER_STATS_EN
  logic out_src;  // source of the word currently on data_out

  always_ff @(posedge clk) begin
    if (reset) begin
      out_src <= 1'b0;
      cnt0    <= 16'd0;
      cnt1    <= 16'd0;
    end else begin
      out_src <= rd_p1_src;
      if (valid_out && !out_src) cnt0 <= cnt0 + 16'd1;
      if (valid_out &&  out_src) cnt1 <= cnt1 + 16'd1;
    end
  end
`endif

endmodule
